ball_position_scanner: RTL and testbench

BALL_POSITION_SCANNER -- requirements
Module: ball_position_scanner

---
 rtl/ball_position_scanner_if.sv | 40 ++++
 rtl/ball_position_scanner.sv | 183 ++++++++++++++++++
 tb/tb_ball_position_scanner.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ball_position_scanner_if.sv
// Signal bundle between the ball position scanner and its sensor matrix / position consumer.
// pos_valid is a valid-only strobe with no ready: the consumer takes x/y/ball_detected in the cycle it is high.
interface ball_position_scanner_if;
    logic       clk_en;
    logic       sensor_in;
    logic [2:0] row_sel;
    logic [2:0] col_sel;
    logic       mux_en;
    logic [3:0] x_pos_calc;
    logic [3:0] y_pos_calc;
    logic       ball_detected;
    logic       pos_valid;
    logic [1:0] dbg_state;

    modport master (
        input  clk_en,
        input  sensor_in,
        output row_sel,
        output col_sel,
        output mux_en,
        output x_pos_calc,
        output y_pos_calc,
        output ball_detected,
        output pos_valid,
        output dbg_state
    );

    modport slave (
        output clk_en,
        output sensor_in,
        input  row_sel,
        input  col_sel,
        input  mux_en,
        input  x_pos_calc,
        input  y_pos_calc,
        input  ball_detected,
        input  pos_valid,
        input  dbg_state
    );
endinterface

// File: rtl/ball_position_scanner.sv
// Scans an 8x5 multiplexed sensor matrix, tracks the bounding box of active sensors
// per frame and publishes its midpoint with a miss-filtered ball_detected flag.
module ball_position_scanner #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned MISS_FRAMES   = 3,
    parameter logic        ACTIVE_LEVEL  = 1'b0
) (
    input logic clk,
    input logic rst_n,
    ball_position_scanner_if.master bus
);

    typedef enum logic [1:0] {
        ST_SETTLE  = 2'd0,
        ST_SAMPLE  = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_PUBLISH = 2'd3
    } state_e;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] MISS_MAX    = 3'(MISS_FRAMES);
    localparam logic [2:0] ROW_LAST    = 3'd7;
    localparam logic [2:0] COL_LAST    = 3'd4;

    state_e     state_q, state_d;
    logic [1:0] sync_q, sync_d;
    logic [3:0] settle_cnt_q, settle_cnt_d;
    logic [2:0] row_q, row_d;
    logic [2:0] col_q, col_d;
    logic       mux_en_q, mux_en_d;
    logic       hit_q, hit_d;
    logic [2:0] xmin_q, xmin_d, xmax_q, xmax_d;
    logic [2:0] ymin_q, ymin_d, ymax_q, ymax_d;
    logic [2:0] calc_x_q, calc_x_d, calc_y_q, calc_y_d;
    logic [2:0] miss_q, miss_d;
    logic [2:0] x_pos_q, x_pos_d, y_pos_q, y_pos_d;
    logic       ball_q, ball_d;
    logic       pos_valid_q, pos_valid_d;
    logic [3:0] sum_x, sum_y;

    always_comb begin
        sync_d       = {sync_q[0], bus.sensor_in};
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        row_d        = row_q;
        col_d        = col_q;
        hit_d        = hit_q;
        xmin_d       = xmin_q;
        xmax_d       = xmax_q;
        ymin_d       = ymin_q;
        ymax_d       = ymax_q;
        calc_x_d     = calc_x_q;
        calc_y_d     = calc_y_q;
        miss_d       = miss_q;
        x_pos_d      = x_pos_q;
        y_pos_d      = y_pos_q;
        ball_d       = ball_q;
        pos_valid_d  = 1'b0;
        sum_x        = {1'b0, xmin_q} + {1'b0, xmax_q};
        sum_y        = {1'b0, ymin_q} + {1'b0, ymax_q};

        if (bus.clk_en) begin
            case (state_q)
                ST_SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        settle_cnt_d = 4'd0;
                        state_d      = ST_SAMPLE;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    if (sync_q[1] == ACTIVE_LEVEL) begin
                        hit_d = 1'b1;
                        // First hit of the frame seeds the box; later hits only widen it.
                        if (!hit_q) begin
                            xmin_d = row_q;
                            xmax_d = row_q;
                            ymin_d = col_q;
                            ymax_d = col_q;
                        end else begin
                            if (row_q < xmin_q) xmin_d = row_q;
                            if (row_q > xmax_q) xmax_d = row_q;
                            if (col_q < ymin_q) ymin_d = col_q;
                            if (col_q > ymax_q) ymax_d = col_q;
                        end
                    end
                    state_d = ST_SETTLE;
                    if (col_q == COL_LAST) begin
                        col_d = 3'd0;
                        if (row_q == ROW_LAST) begin
                            row_d   = 3'd0;
                            state_d = ST_COMPUTE;
                        end else begin
                            row_d = row_q + 3'd1;
                        end
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                end
                ST_COMPUTE: begin
                    calc_x_d = sum_x[3:1];
                    calc_y_d = sum_y[3:1];
                    state_d  = ST_PUBLISH;
                end
                ST_PUBLISH: begin
                    pos_valid_d = 1'b1;
                    state_d     = ST_SETTLE;
                    if (hit_q) begin
                        x_pos_d = calc_x_q;
                        y_pos_d = calc_y_q;
                        ball_d  = 1'b1;
                        miss_d  = 3'd0;
                    end else begin
                        miss_d = (miss_q == MISS_MAX) ? miss_q : miss_q + 3'd1;
                        if (miss_d == MISS_MAX) ball_d = 1'b0;
                    end
                    hit_d  = 1'b0;
                    xmin_d = 3'd0;
                    xmax_d = 3'd0;
                    ymin_d = 3'd0;
                    ymax_d = 3'd0;
                end
                default: state_d = ST_SETTLE;
            endcase
        end

        // Registered so mux_en is low during reset and follows the state it will be in.
        mux_en_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_SETTLE;
            sync_q       <= 2'b00;
            settle_cnt_q <= 4'd0;
            row_q        <= 3'd0;
            col_q        <= 3'd0;
            mux_en_q     <= 1'b0;
            hit_q        <= 1'b0;
            xmin_q       <= 3'd0;
            xmax_q       <= 3'd0;
            ymin_q       <= 3'd0;
            ymax_q       <= 3'd0;
            calc_x_q     <= 3'd0;
            calc_y_q     <= 3'd0;
            miss_q       <= 3'd0;
            x_pos_q      <= 3'd0;
            y_pos_q      <= 3'd0;
            ball_q       <= 1'b0;
            pos_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            settle_cnt_q <= settle_cnt_d;
            row_q        <= row_d;
            col_q        <= col_d;
            mux_en_q     <= mux_en_d;
            hit_q        <= hit_d;
            xmin_q       <= xmin_d;
            xmax_q       <= xmax_d;
            ymin_q       <= ymin_d;
            ymax_q       <= ymax_d;
            calc_x_q     <= calc_x_d;
            calc_y_q     <= calc_y_d;
            miss_q       <= miss_d;
            x_pos_q      <= x_pos_d;
            y_pos_q      <= y_pos_d;
            ball_q       <= ball_d;
            pos_valid_q  <= pos_valid_d;
        end
    end

    assign bus.row_sel       = row_q;
    assign bus.col_sel       = col_q;
    assign bus.mux_en        = mux_en_q;
    assign bus.x_pos_calc    = {1'b0, x_pos_q};
    assign bus.y_pos_calc    = {1'b0, y_pos_q};
    assign bus.ball_detected = ball_q;
    assign bus.pos_valid     = pos_valid_q;
    assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_ball_position_scanner.sv
// Directed bench for ball_position_scanner: models the sensor matrix and checks
// publish timing, positions, miss filtering, clock-enable gating and reset.
module tb_ball_position_scanner;

    logic        clk;
    logic        rst_n;
    logic [39:0] act_map;
    int          en_quarter;
    int          tick_ph;
    int          n_checks;
    int          n_errors;
    int          pending;
    logic [6:0]  h1, h2, h3;

    ball_position_scanner_if bus();

    ball_position_scanner dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    // Sensor matrix model: active sensors read low while addressed.
    always_comb begin
        logic [5:0] idx;
        idx = 6'({3'b000, bus.row_sel} * 6'd5 + {3'b000, bus.col_sel});
        if (bus.mux_en && idx < 6'd40 && act_map[idx]) bus.sensor_in = 1'b0;
        else                                           bus.sensor_in = 1'b1;
    end

    // Clock-enable driver: constant, or one cycle in four.
    initial begin
        tick_ph    = 0;
        bus.clk_en = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tick_ph    = tick_ph + 1;
            bus.clk_en = (en_quarter == 0) || (tick_ph % 4 == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_hit(input int r, input int c);
        act_map[6'(r * 5 + c)] = 1'b1;
    endtask

    // Waits for the next publish, then checks interval, outputs, scan tail and pulse width.
    task automatic check_frame(input string tag, input int budget, input int exp_len,
                               input logic [3:0] ex, input logic [3:0] ey,
                               input logic eb, input bit chk_tail);
        int clks;
        bit seen;
        clks = pending;
        seen = 1'b0;
        h1 = '0; h2 = '0; h3 = '0;
        while (!seen && clks < budget) begin
            @(negedge clk);
            clks++;
            if (bus.pos_valid) seen = 1'b1;
            else begin
                h3 = h2;
                h2 = h1;
                h1 = {bus.mux_en, bus.row_sel, bus.col_sel};
            end
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        if (exp_len > 0) check({tag, "_len"}, 32'(clks), 32'(exp_len));
        check({tag, "_x"}, 32'(bus.x_pos_calc), 32'(ex));
        check({tag, "_y"}, 32'(bus.y_pos_calc), 32'(ey));
        check({tag, "_bd"}, 32'(bus.ball_detected), 32'(eb));
        if (chk_tail) begin
            check({tag, "_last_sample"}, 32'(h3), 32'(7'b1_111_100));
            check({tag, "_compute_bus"}, 32'(h2), 32'd0);
            check({tag, "_publish_bus"}, 32'(h1), 32'd0);
        end
        @(negedge clk);
        check({tag, "_pv_width"}, 32'(bus.pos_valid), 32'd0);
        check({tag, "_restart"}, 32'(bus.dbg_state), 32'd0);
        pending = 1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_x"}, 32'(bus.x_pos_calc), 32'd0);
        check({tag, "_y"}, 32'(bus.y_pos_calc), 32'd0);
        check({tag, "_bd"}, 32'(bus.ball_detected), 32'd0);
        check({tag, "_pv"}, 32'(bus.pos_valid), 32'd0);
        check({tag, "_row"}, 32'(bus.row_sel), 32'd0);
        check({tag, "_col"}, 32'(bus.col_sel), 32'd0);
        check({tag, "_mux_en"}, 32'(bus.mux_en), 32'd0);
        check({tag, "_state"}, 32'(bus.dbg_state), 32'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        pending    = 0;
        en_quarter = 0;
        act_map    = '0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        rst_n   = 1'b1;
        pending = 0;
        check_frame("idle1", 400, 202, 4'd0, 4'd0, 1'b0, 1'b1);
        check_frame("idle2", 400, 202, 4'd0, 4'd0, 1'b0, 1'b1);

        act_map = '0; set_hit(5, 3);
        check_frame("single", 400, 202, 4'd5, 4'd3, 1'b1, 1'b1);

        act_map = '0; set_hit(1, 0); set_hit(6, 4);
        check_frame("bbox", 400, 202, 4'd3, 4'd2, 1'b1, 1'b1);

        act_map = '0; set_hit(2, 1);
        check_frame("hold_hit", 400, 202, 4'd2, 4'd1, 1'b1, 1'b1);
        act_map = '0;
        check_frame("miss1", 400, 202, 4'd2, 4'd1, 1'b1, 1'b1);
        check_frame("miss2", 400, 202, 4'd2, 4'd1, 1'b1, 1'b1);
        check_frame("miss3", 400, 202, 4'd2, 4'd1, 1'b0, 1'b1);
        check_frame("miss4", 400, 202, 4'd2, 4'd1, 1'b0, 1'b1);

        en_quarter = 1;
        act_map = '0; set_hit(5, 3);
        check_frame("quarter_a", 1000, -1, 4'd5, 4'd3, 1'b1, 1'b0);
        check_frame("quarter_b", 1000, 808, 4'd5, 4'd3, 1'b1, 1'b0);

        en_quarter = 0;
        act_map = '0; set_hit(4, 4);
        check_frame("pre_rst", 1000, -1, 4'd4, 4'd4, 1'b1, 1'b1);
        repeat (99) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        pending = 0;
        check_frame("post_rst", 400, 202, 4'd4, 4'd4, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
